// File: rtl/pw_verify_if.sv
// Keypad/password bus between the entry panel side and the verifier.
// Carries the stored password, key strobes, and the verifier status back.
interface pw_verify_if #(
   parameter int unsigned MAX_LEN   = 4,
   parameter int unsigned CHAR_W    = 2,
   parameter int unsigned MAX_FAILS = 3
);
   localparam int unsigned LEN_W  = $clog2(MAX_LEN + 1);
   localparam int unsigned FAIL_W = $clog2(MAX_FAILS + 1);

   logic [MAX_LEN*CHAR_W-1:0] pw_set;
   logic [LEN_W-1:0]          pw_length;
   logic                      key_valid;
   logic [CHAR_W-1:0]         key_bits;
   logic                      compare;
   logic                      clear;
   logic                      unlocked;
   logic                      locked_out;
   logic                      fail_pulse;
   logic [LEN_W-1:0]          entry_count;
   logic [FAIL_W-1:0]         fail_count;

   modport master (
      output pw_set, pw_length, key_valid, key_bits, compare, clear,
      input  unlocked, locked_out, fail_pulse, entry_count, fail_count
   );

   modport slave (
      input  pw_set, pw_length, key_valid, key_bits, compare, clear,
      output unlocked, locked_out, fail_pulse, entry_count, fail_count
   );
endinterface

// File: rtl/pw_verify_fsm.sv
// Password verifier: checks keypad chars on the fly against the stored
// password, drives the unlock window and a timed lockout after repeated fails.
module pw_verify_fsm #(
   parameter int unsigned MAX_LEN        = 4,
   parameter int unsigned CHAR_W         = 2,
   parameter int unsigned MAX_FAILS      = 3,
   parameter int unsigned LOCKOUT_CYCLES = 1000,
   parameter int unsigned UNLOCK_CYCLES  = 500
) (
   input logic          clk,
   input logic          resetn,
   pw_verify_if.slave   bus
);
   localparam int unsigned LEN_W   = $clog2(MAX_LEN + 1);
   localparam int unsigned FAIL_W  = $clog2(MAX_FAILS + 1);
   localparam int unsigned TMR_MAX = (LOCKOUT_CYCLES > UNLOCK_CYCLES) ? LOCKOUT_CYCLES : UNLOCK_CYCLES;
   localparam int unsigned TMR_W   = $clog2(TMR_MAX);

   typedef enum logic [1:0] {
      IDLE,
      ENTRY,
      UNLOCKED,
      LOCKOUT
   } state_e;

   state_e             state_q, state_d;
   logic [LEN_W-1:0]   entry_count_q, entry_count_d;
   logic [FAIL_W-1:0]  fail_count_q, fail_count_d;
   logic               mismatch_q, mismatch_d;
   logic               overflow_q, overflow_d;
   logic [TMR_W-1:0]   timer_q, timer_d;
   logic               unlocked_q, unlocked_d;
   logic               locked_out_q, locked_out_d;
   logic               fail_pulse_q, fail_pulse_d;

   logic [CHAR_W-1:0]  exp_char;
   logic [FAIL_W-1:0]  fail_inc;
   logic               match;

   // Stored char at the current entry position; mux keeps the select in range.
   always_comb begin
      exp_char = '0;
      for (int unsigned i = 0; i < MAX_LEN; i++) begin
         if (entry_count_q == LEN_W'(i)) begin
            exp_char = bus.pw_set[i*CHAR_W +: CHAR_W];
         end
      end
   end

   assign match = !mismatch_q && !overflow_q &&
                  (entry_count_q == bus.pw_length) && (bus.pw_length != '0);
   assign fail_inc = fail_count_q + FAIL_W'(1);

   always_comb begin
      state_d       = state_q;
      entry_count_d = entry_count_q;
      fail_count_d  = fail_count_q;
      mismatch_d    = mismatch_q;
      overflow_d    = overflow_q;
      timer_d       = timer_q;
      fail_pulse_d  = 1'b0;

      case (state_q)
         IDLE, ENTRY: begin
            // Priority: clear, then compare, then key.
            if (bus.clear) begin
               entry_count_d = '0;
               mismatch_d    = 1'b0;
               overflow_d    = 1'b0;
               state_d       = IDLE;
            end else if (bus.compare) begin
               entry_count_d = '0;
               mismatch_d    = 1'b0;
               overflow_d    = 1'b0;
               timer_d       = '0;
               if (match) begin
                  state_d      = UNLOCKED;
                  fail_count_d = '0;
               end else begin
                  fail_pulse_d = 1'b1;
                  fail_count_d = fail_inc;
                  state_d      = (fail_inc == FAIL_W'(MAX_FAILS)) ? LOCKOUT : IDLE;
               end
            end else if (bus.key_valid) begin
               state_d = ENTRY;
               if (entry_count_q < LEN_W'(MAX_LEN)) begin
                  if ((bus.key_bits != exp_char) || (entry_count_q >= bus.pw_length)) begin
                     mismatch_d = 1'b1;
                  end
                  entry_count_d = entry_count_q + LEN_W'(1);
               end else begin
                  overflow_d = 1'b1;
               end
            end
         end
         UNLOCKED: begin
            if (timer_q == TMR_W'(UNLOCK_CYCLES - 1)) begin
               state_d = IDLE;
            end else begin
               timer_d = timer_q + TMR_W'(1);
            end
         end
         LOCKOUT: begin
            if (timer_q == TMR_W'(LOCKOUT_CYCLES - 1)) begin
               state_d      = IDLE;
               fail_count_d = '0;
            end else begin
               timer_d = timer_q + TMR_W'(1);
            end
         end
      endcase

      unlocked_d   = (state_d == UNLOCKED);
      locked_out_d = (state_d == LOCKOUT);
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q       <= IDLE;
         entry_count_q <= '0;
         fail_count_q  <= '0;
         mismatch_q    <= 1'b0;
         overflow_q    <= 1'b0;
         timer_q       <= '0;
         unlocked_q    <= 1'b0;
         locked_out_q  <= 1'b0;
         fail_pulse_q  <= 1'b0;
      end else begin
         state_q       <= state_d;
         entry_count_q <= entry_count_d;
         fail_count_q  <= fail_count_d;
         mismatch_q    <= mismatch_d;
         overflow_q    <= overflow_d;
         timer_q       <= timer_d;
         unlocked_q    <= unlocked_d;
         locked_out_q  <= locked_out_d;
         fail_pulse_q  <= fail_pulse_d;
      end
   end

   assign bus.unlocked    = unlocked_q;
   assign bus.locked_out  = locked_out_q;
   assign bus.fail_pulse  = fail_pulse_q;
   assign bus.entry_count = entry_count_q;
   assign bus.fail_count  = fail_count_q;

endmodule

// File: tb/tb_pw_verify_fsm.sv
// Scoreboard bench for pw_verify_fsm: stimulus queues expected fail/unlock/
// lockout events, a monitor pops and checks them as the DUT produces them.
module tb_pw_verify_fsm;
   localparam int EV_FAIL   = 0;
   localparam int EV_UNLOCK = 1;
   localparam int EV_LOCK   = 2;

   typedef struct {
      int kind;
      int fc;
      int lo;
      int len;
   } exp_t;

   logic clk;
   logic resetn;
   int   n_vec  = 0;
   int   n_miss = 0;
   exp_t sb_q[$];

   bit   mon_pf = 1'b0;
   bit   mon_pu = 1'b0;
   bit   mon_pl = 1'b0;
   int   mon_ulen = 0;
   int   mon_llen = 0;

   pw_verify_if #(.MAX_LEN(4), .CHAR_W(2), .MAX_FAILS(3)) bus ();

   pw_verify_fsm #(
      .MAX_LEN(4), .CHAR_W(2), .MAX_FAILS(3),
      .LOCKOUT_CYCLES(1000), .UNLOCK_CYCLES(500)
   ) dut (
      .clk    (clk),
      .resetn (resetn),
      .bus    (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_miss++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endtask

   task automatic pop_chk(input int kind, input string nm, output exp_t e, output bit ok);
      n_vec++;
      ok = 1'b0;
      e  = '{kind: -1, fc: 0, lo: 0, len: 0};
      if (sb_q.size() == 0) begin
         n_miss++;
         $display("FAIL %s: got unexpected event kind %0d, expected none", nm, kind);
      end else begin
         e = sb_q.pop_front();
         if (e.kind != kind) begin
            n_miss++;
            $display("FAIL %s: got event kind %0d, expected kind %0d", nm, kind, e.kind);
         end else begin
            ok = 1'b1;
         end
      end
   endtask

   function automatic void exp_fail(input int fc, input int lo);
      sb_q.push_back('{kind: EV_FAIL, fc: fc, lo: lo, len: 0});
   endfunction

   function automatic void exp_unlock();
      sb_q.push_back('{kind: EV_UNLOCK, fc: 0, lo: 0, len: 500});
   endfunction

   function automatic void exp_lock(input int len);
      sb_q.push_back('{kind: EV_LOCK, fc: 0, lo: 0, len: len});
   endfunction

   // One-cycle strobe of any input combination, driven away from the clock edge.
   task automatic strobe(input bit kv, input logic [1:0] kb, input bit cmp, input bit clr);
      @(posedge clk); #1;
      bus.key_valid = kv;
      bus.key_bits  = kb;
      bus.compare   = cmp;
      bus.clear     = clr;
      @(posedge clk); #1;
      bus.key_valid = 1'b0;
      bus.compare   = 1'b0;
      bus.clear     = 1'b0;
   endtask

   // Enter n keys; key i is ks[2*i +: 2].
   task automatic enter(input int n, input logic [9:0] ks);
      for (int i = 0; i < n; i++) begin
         strobe(1'b1, ks[2*i +: 2], 1'b0, 1'b0);
      end
   endtask

   task automatic wait_low(input bit lock_sel, input int bound, input string nm);
      bit done = 1'b0;
      for (int i = 0; i < bound && !done; i++) begin
         @(negedge clk);
         if ((lock_sel ? bus.locked_out : bus.unlocked) === 1'b0) done = 1'b1;
      end
      chk(nm, int'(done), 1);
   endtask

   // Monitor: every fail pulse and every end of an unlock/lockout window is an event.
   initial begin : monitor
      exp_t e;
      bit   ok;
      forever begin
         @(negedge clk);
         if (bus.fail_pulse === 1'b1) begin
            chk("fail_pulse_one_cycle", int'(mon_pf), 0);
            pop_chk(EV_FAIL, "fail_event", e, ok);
            if (ok) begin
               chk("fail_count_at_fail", int'(bus.fail_count), e.fc);
               chk("locked_out_at_fail", int'(bus.locked_out), e.lo);
            end
         end
         if (bus.unlocked === 1'b1) begin
            mon_ulen++;
         end else if (mon_pu) begin
            pop_chk(EV_UNLOCK, "unlock_event", e, ok);
            if (ok) chk("unlock_cycles", mon_ulen, e.len);
            mon_ulen = 0;
         end
         if (bus.locked_out === 1'b1) begin
            mon_llen++;
         end else if (mon_pl) begin
            pop_chk(EV_LOCK, "lockout_event", e, ok);
            if (ok) chk("lockout_cycles", mon_llen, e.len);
            mon_llen = 0;
         end
         mon_pf = (bus.fail_pulse === 1'b1);
         mon_pu = (bus.unlocked === 1'b1);
         mon_pl = (bus.locked_out === 1'b1);
      end
   end

   initial begin : watchdog
      #300000;
      $display("FAIL watchdog: got no end of test, expected $finish before time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin : stimulus
      resetn        = 1'b0;
      bus.pw_set    = 8'h1B;   // chars 3,2,1,0
      bus.pw_length = 3'd4;
      bus.key_valid = 1'b0;
      bus.key_bits  = 2'd0;
      bus.compare   = 1'b0;
      bus.clear     = 1'b0;
      repeat (3) @(posedge clk);
      #1 resetn = 1'b1;

      @(negedge clk);
      chk("reset_unlocked",    int'(bus.unlocked),    0);
      chk("reset_locked_out",  int'(bus.locked_out),  0);
      chk("reset_fail_pulse",  int'(bus.fail_pulse),  0);
      chk("reset_entry_count", int'(bus.entry_count), 0);
      chk("reset_fail_count",  int'(bus.fail_count),  0);

      // Correct entry; strobes during the unlock window are ignored
      enter(4, 10'h01B);
      @(negedge clk);
      chk("correct_entry_count", int'(bus.entry_count), 4);
      exp_unlock();
      strobe(1'b0, 2'd0, 1'b1, 1'b0);
      @(negedge clk);
      chk("correct_unlocked", int'(bus.unlocked), 1);
      chk("correct_fail_count", int'(bus.fail_count), 0);
      chk("correct_entry_cleared", int'(bus.entry_count), 0);
      strobe(1'b1, 2'd3, 1'b0, 1'b0);
      strobe(1'b0, 2'd0, 1'b1, 1'b0);
      strobe(1'b0, 2'd0, 1'b0, 1'b1);
      wait_low(1'b0, 600, "unlock_end_timeout");
      chk("unlock_keys_ignored", int'(bus.entry_count), 0);

      // Wrong char
      enter(4, 10'h02B);
      exp_fail(1, 0);
      strobe(1'b0, 2'd0, 1'b1, 1'b0);
      @(negedge clk);
      chk("wrong_unlocked", int'(bus.unlocked), 0);
      chk("wrong_entry_cleared", int'(bus.entry_count), 0);

      // Too short
      enter(3, 10'h01B);
      exp_fail(2, 0);
      strobe(1'b0, 2'd0, 1'b1, 1'b0);

      // Correct entry resets the fail count
      enter(4, 10'h01B);
      exp_unlock();
      strobe(1'b0, 2'd0, 1'b1, 1'b0);
      @(negedge clk);
      chk("reunlock_fail_count", int'(bus.fail_count), 0);
      wait_low(1'b0, 600, "reunlock_end_timeout");

      // Overflow: fifth key saturates entry_count
      enter(5, 10'h31B);
      @(negedge clk);
      chk("overflow_entry_count", int'(bus.entry_count), 4);
      exp_fail(1, 0);
      strobe(1'b0, 2'd0, 1'b1, 1'b0);

      // key_valid with compare: final key is discarded
      enter(3, 10'h01B);
      exp_fail(2, 0);
      strobe(1'b1, 2'd0, 1'b1, 1'b0);
      @(negedge clk);
      chk("keycmp_unlocked", int'(bus.unlocked), 0);
      chk("keycmp_entry_count", int'(bus.entry_count), 0);

      // clear with compare: no fail, fail count kept
      enter(4, 10'h01B);
      strobe(1'b0, 2'd0, 1'b1, 1'b1);
      @(negedge clk);
      chk("clrcmp_entry_count", int'(bus.entry_count), 0);
      chk("clrcmp_fail_count", int'(bus.fail_count), 2);
      enter(2, 10'h01B);
      strobe(1'b1, 2'd1, 1'b0, 1'b1);
      @(negedge clk);
      chk("clrkey_entry_count", int'(bus.entry_count), 0);

      // Zero chars entered is a fail; third consecutive fail locks out
      exp_fail(3, 1);
      exp_lock(1000);
      strobe(1'b0, 2'd0, 1'b1, 1'b0);
      @(negedge clk);
      chk("lockout_active", int'(bus.locked_out), 1);
      enter(4, 10'h01B);
      strobe(1'b0, 2'd0, 1'b1, 1'b0);
      chk("lockout_keys_ignored", int'(bus.entry_count), 0);
      wait_low(1'b1, 1100, "lockout_end_timeout");
      chk("lockout_exit_fail_count", int'(bus.fail_count), 0);

      // Three wrong attempts, then reset 400 cycles into lockout
      for (int i = 0; i < 3; i++) begin
         enter(4, 10'h02B);
         exp_fail(i + 1, (i == 2) ? 1 : 0);
         if (i == 2) exp_lock(400);
         strobe(1'b0, 2'd0, 1'b1, 1'b0);
      end
      repeat (399) @(posedge clk);
      #1 resetn = 1'b0;
      @(posedge clk);
      #1 resetn = 1'b1;
      @(negedge clk);
      chk("rst_lock_locked_out", int'(bus.locked_out), 0);
      chk("rst_lock_fail_count", int'(bus.fail_count), 0);
      enter(4, 10'h01B);
      exp_unlock();
      strobe(1'b0, 2'd0, 1'b1, 1'b0);
      @(negedge clk);
      chk("rst_lock_unlocked", int'(bus.unlocked), 1);
      wait_low(1'b0, 600, "rst_unlock_end_timeout");

      // pw_length = 0 always fails
      bus.pw_length = 3'd0;
      exp_fail(1, 0);
      strobe(1'b0, 2'd0, 1'b1, 1'b0);
      @(negedge clk);
      chk("len0_unlocked", int'(bus.unlocked), 0);

      // pw_length = 3: three right keys unlock, a fourth key fails
      bus.pw_length = 3'd3;
      enter(3, 10'h01B);
      exp_unlock();
      strobe(1'b0, 2'd0, 1'b1, 1'b0);
      wait_low(1'b0, 600, "len3_unlock_end_timeout");
      enter(4, 10'h01B);
      exp_fail(1, 0);
      strobe(1'b0, 2'd0, 1'b1, 1'b0);
      bus.pw_length = 3'd4;

      repeat (5) @(posedge clk);
      @(negedge clk);
      chk("scoreboard_drained", sb_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end
endmodule

// File: doc/pw_verify_fsm.md
Name: pw_verify_fsm

Overview:
- Downstream consumer of the password setup panel. Takes the stored password (characters plus `pw_length`) and a live stream of keypad characters, and decides unlock or fail.
- Compares each character on the fly, counts failed attempts, and enforces a timed lockout after repeated failures.
- Drives the lock actuator enable (`unlocked`) and the status LEDs.

Parameters:
- MAX_LEN, 4, maximum password length in characters.
- CHAR_W, 2, bits per keypad character.
- MAX_FAILS, 3, consecutive failed attempts that trigger lockout (≥1).
- LOCKOUT_CYCLES, 1000, clock cycles spent in LOCKOUT (≥2).
- UNLOCK_CYCLES, 500, clock cycles `unlocked` stays high (≥2).

Ports:
- clk  in  1  system clock, all logic on posedge.
- resetn  in  1  reset, synchronous, active-low.
- pw_set  in  MAX_LEN*CHAR_W  stored password, flattened; char i is at [i*CHAR_W +: CHAR_W]; char 0 is entered first.
- pw_length  in  $clog2(MAX_LEN+1)  number of valid stored chars (0..MAX_LEN).
- key_valid  in  1  single-cycle strobe: key_bits holds an entered char.
- key_bits  in  CHAR_W  entered character.
- compare  in  1  single-cycle submit strobe.
- clear  in  1  single-cycle strobe: discard the current entry.
- unlocked  out  1  high during UNLOCKED.
- locked_out  out  1  high during LOCKOUT.
- fail_pulse  out  1  one-cycle pulse on each failed attempt.
- entry_count  out  $clog2(MAX_LEN+1)  chars accepted in the current attempt, saturating at MAX_LEN.
- fail_count  out  $clog2(MAX_FAILS+1)  consecutive failed attempts.

Behaviour:
- Reset (resetn low at posedge):
  - state=IDLE; `unlocked`, `locked_out`, `fail_pulse` = 0; `entry_count`, `fail_count`, `mismatch`, `overflow` = 0.
  - Reset overrides everything, including mid-LOCKOUT and mid-UNLOCKED; all timers clear.
- States: IDLE, ENTRY, UNLOCKED, LOCKOUT. All outputs are registered.
- IDLE/ENTRY, key_valid=1 (no compare, no clear):
  - If entry_count < MAX_LEN: compare key_bits with char[entry_count]; set sticky `mismatch` if they differ or if entry_count ≥ pw_length; entry_count+1.
  - If entry_count = MAX_LEN: key ignored, entry_count stays, sticky `overflow` set.
  - State moves to ENTRY.
- Match rule on compare: match = !mismatch && !overflow && entry_count == pw_length && pw_length != 0.
- Compare in IDLE/ENTRY is evaluated at that same posedge (1-cycle latency to outputs):
  - Match: next state UNLOCKED; `unlocked`=1 from the next cycle; fail_count → 0.
  - Fail: `fail_pulse`=1 for exactly one cycle; fail_count+1.
    - If the new count = MAX_FAILS: go to LOCKOUT, `locked_out`=1.
    - Otherwise: go to IDLE.
  - Either outcome clears entry_count, mismatch and overflow.
- Compare with zero chars entered: counts as a fail (pw_length=0 always fails).
- Simultaneous events:
  - clear beats compare and key_valid.
  - compare beats key_valid; the key in the same cycle is discarded.
- clear: entry_count, mismatch and overflow → 0; state → IDLE; fail_count untouched.
- UNLOCKED:
  - Timer counts UNLOCK_CYCLES; `unlocked` is high for exactly UNLOCK_CYCLES cycles, then state → IDLE.
  - key_valid, compare and clear are ignored.
- LOCKOUT:
  - `locked_out` is high for exactly LOCKOUT_CYCLES cycles; inputs are ignored.
  - On exit: state → IDLE, fail_count → 0.
- pw_set and pw_length are read live. Changing them during ENTRY gives defined but unspecified match results; the verifier must not check that case.
- Counter widths are sized exactly from the parameters; no wrap is possible because entry_count and fail_count saturate or reset.

Test Plan:
- Correct entry: pw_set = chars {3,2,1,0}, pw_length=4; keys 3,2,1,0, then compare → next cycle unlocked=1 for 500 cycles, fail_count=0, then IDLE.
- Wrong char: keys 3,2,2,0, compare → fail_pulse one cycle, fail_count=1, unlocked stays 0.
- Length errors:
  - Keys 3,2,1, compare → fail.
  - Keys 3,2,1,0,3, compare → overflow, fail; entry_count saturates at 4.
- Lockout: three wrong attempts → third compare gives locked_out=1 for 1000 cycles; keys/compare during lockout produce no fail_pulse; on exit fail_count=0.
- Simultaneous strobes:
  - key_valid with compare in the same cycle after keys 3,2,1 → key discarded, fail.
  - clear with compare → no fail_pulse, entry_count=0.
- Reset mid-LOCKOUT (cycle 400): resetn low one cycle → locked_out=0, state IDLE, fail_count=0; the correct sequence then unlocks.
